// File: rtl/control_sequencer_if.sv
// Connects the control sequencer to the datapath.
// Carries the instruction register and flags in, and the T-state and the 16 control lines out.
interface control_sequencer_if #(
  parameter int N = 8
);
  logic [N-1:0] irval;
  logic         cf;
  logic         zf;
  logic         prog;
  logic [2:0]   step;
  logic         hlt;
  logic         mi;
  logic         ri;
  logic         ro;
  logic         io;
  logic         ii;
  logic         ai;
  logic         ao;
  logic         eo;
  logic         su;
  logic         bi;
  logic         oi;
  logic         ce;
  logic         co;
  logic         j;
  logic         fi;

  modport master (
    input  irval, cf, zf, prog,
    output step,
    output hlt, mi, ri, ro, io, ii, ai, ao,
    output eo, su, bi, oi, ce, co, j, fi
  );

  modport slave (
    output irval, cf, zf, prog,
    input  step,
    input  hlt, mi, ri, ro, io, ii, ai, ao,
    input  eo, su, bi, oi, ce, co, j, fi
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit bus computer.
// A falling-edge T-state counter plus a combinational microcode decoder drives the 16 control lines.
module control_sequencer_chk (
  input logic       clk,
  input logic       clr_,
  input logic [4:0] drivers_i
);
  a_bus_exclusive: assert property (@(posedge clk) disable iff (!clr_) $onehot0(drivers_i));
endmodule

module control_sequencer #(
  parameter int N     = 8,
  parameter int STEPS = 5
) (
  input logic                 clk,
  input logic                 clr_,
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6,
    T7 = 3'd7
  } tstate_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word bit order, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;
  localparam logic [15:0] C_NONE = 16'h0000;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  tstate_e     step_q;
  tstate_e     step_d;
  logic        run_q;
  logic [3:0]  opcode_s;
  logic        halt_s;
  logic [15:0] ucode_s;
  logic [15:0] ctrl_s;
  logic        unused_operand_s;

  assign opcode_s         = bus.irval[N-1 -: 4];
  assign unused_operand_s = ^bus.irval[N-5:0];
  assign halt_s           = (step_q == T2) && (opcode_s == OP_HLT);

  // Reset release synchroniser: the counter is allowed to move one falling edge after clr_ rises
  always_ff @(negedge clk or negedge clr_) begin
    if (!clr_) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // T-state register
  always_ff @(negedge clk or negedge clr_) begin
    if (!clr_) begin
      step_q <= T0;
    end else begin
      step_q <= step_d;
    end
  end

  // Next T-state; halt is only left through clr_, so it outranks manual program mode
  always_comb begin
    step_d = step_q;
    if (!run_q) begin
      step_d = T0;
    end else if (halt_s) begin
      step_d = step_q;
    end else if (!bus.prog) begin
      step_d = T0;
    end else if (step_q == LAST_STEP) begin
      step_d = T0;
    end else begin
      step_d = tstate_e'(step_q + 3'd1);
    end
  end

  // Microcode ROM: fetch on T0/T1, opcode-specific execute on T2..T4, zero elsewhere
  always_comb begin
    ucode_s = C_NONE;
    case (step_q)
      T0: ucode_s = C_CO | C_MI;
      T1: ucode_s = C_RO | C_II | C_CE;
      T2: begin
        case (opcode_s)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ucode_s = C_IO | C_MI;
          OP_LDI: ucode_s = C_IO | C_AI;
          OP_JMP: ucode_s = C_IO | C_J;
          OP_JC: begin
            if (bus.cf) begin
              ucode_s = C_IO | C_J;
            end else begin
              ucode_s = C_NONE;
            end
          end
          OP_JZ: begin
            if (bus.zf) begin
              ucode_s = C_IO | C_J;
            end else begin
              ucode_s = C_NONE;
            end
          end
          OP_OUT:  ucode_s = C_AO | C_OI;
          OP_HLT:  ucode_s = C_HLT;
          default: ucode_s = C_NONE;
        endcase
      end
      T3: begin
        case (opcode_s)
          OP_LDA:         ucode_s = C_RO | C_AI;
          OP_ADD, OP_SUB: ucode_s = C_RO | C_BI;
          OP_STA:         ucode_s = C_AO | C_RI;
          default:        ucode_s = C_NONE;
        endcase
      end
      T4: begin
        case (opcode_s)
          OP_ADD:  ucode_s = C_EO | C_AI | C_FI;
          OP_SUB:  ucode_s = C_EO | C_AI | C_SU | C_FI;
          default: ucode_s = C_NONE;
        endcase
      end
      default: ucode_s = C_NONE;
    endcase
  end

  assign ctrl_s   = bus.prog ? ucode_s : C_NONE;
  assign bus.step = bus.prog ? step_q : T0;

  assign bus.hlt = ctrl_s[15];
  assign bus.mi  = ctrl_s[14];
  assign bus.ri  = ctrl_s[13];
  assign bus.ro  = ctrl_s[12];
  assign bus.io  = ctrl_s[11];
  assign bus.ii  = ctrl_s[10];
  assign bus.ai  = ctrl_s[9];
  assign bus.ao  = ctrl_s[8];
  assign bus.eo  = ctrl_s[7];
  assign bus.su  = ctrl_s[6];
  assign bus.bi  = ctrl_s[5];
  assign bus.oi  = ctrl_s[4];
  assign bus.ce  = ctrl_s[3];
  assign bus.co  = ctrl_s[2];
  assign bus.j   = ctrl_s[1];
  assign bus.fi  = ctrl_s[0];

  control_sequencer_chk u_chk (
    .clk       (clk),
    .clr_      (clr_),
    .drivers_i ({bus.ro, bus.io, bus.ao, bus.eo, bus.co})
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each expected {step, control word} is queued with
// its stimulus and popped when the DUT output is sampled in the clock-low phase.
module tb_control_sequencer;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;
  localparam logic [15:0] NONE  = 16'h0000;
  localparam logic [15:0] FETCH = RO | II | CE;
  localparam logic [15:0] T0W   = CO | MI;

  typedef struct {
    string       tag;
    logic [18:0] word;
  } exp_t;

  logic clk = 1'b1;
  logic clr_;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  control_sequencer_if #(.N(8)) bus ();

  control_sequencer #(.N(8), .STEPS(5)) dut (
    .clk  (clk),
    .clr_ (clr_),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctrl_obs();
    return {bus.hlt, bus.mi, bus.ri, bus.ro, bus.io, bus.ii, bus.ai, bus.ao,
            bus.eo, bus.su, bus.bi, bus.oi, bus.ce, bus.co, bus.j, bus.fi};
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] s, input logic [15:0] c);
    exp_t e;
    e.tag  = tag;
    e.word = {s, c};
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    int   drivers;
    if (exp_q.size() == 0) begin
      check_value("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_value(e.tag, {13'd0, bus.step, ctrl_obs()}, {13'd0, e.word});
      drivers = int'(bus.ro) + int'(bus.io) + int'(bus.ao) + int'(bus.eo) + int'(bus.co);
      check_value({e.tag, "_busx"}, 32'(drivers <= 1), 32'd1);
    end
  endtask

  // Advance one falling edge, then check in the low phase
  task automatic step_and_check(input string tag, input logic [2:0] s, input logic [15:0] c);
    push_exp(tag, s, c);
    @(negedge clk);
    #2;
    pop_cmp();
  endtask

  // Check without any clock edge
  task automatic check_now(input string tag, input logic [2:0] s, input logic [15:0] c);
    push_exp(tag, s, c);
    #1;
    pop_cmp();
  endtask

  task automatic goto_t0();
    int n = 0;
    while (bus.step != 3'd0 && n < 16) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (bus.step != 3'd0) check_value("goto_t0_timeout", 32'(bus.step), 32'd0);
  endtask

  task automatic run_instr(input string name, input logic [7:0] ir,
                           input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    bus.irval = ir;
    step_and_check({name, "_t1"}, 3'd1, FETCH);
    step_and_check({name, "_t2"}, 3'd2, w2);
    step_and_check({name, "_t3"}, 3'd3, w3);
    step_and_check({name, "_t4"}, 3'd4, w4);
    step_and_check({name, "_t0"}, 3'd0, T0W);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  ops [4];
    logic [15:0] t2w [4];
    ops = '{8'h5C, 8'h63, 8'hE0, 8'h9F};
    t2w = '{IO | AI, IO | J, AO | OI, NONE};

    clr_      = 1'b0;
    bus.prog  = 1'b0;
    bus.irval = 8'h00;
    bus.cf    = 1'b0;
    bus.zf    = 1'b0;

    // Reset with and without manual program mode
    check_now("rst_prog0", 3'd0, NONE);
    bus.prog = 1'b1;
    check_now("rst_t0", 3'd0, T0W);
    step_and_check("rst_hold", 3'd0, T0W);
    clr_ = 1'b1;
    step_and_check("sync", 3'd0, T0W);
    step_and_check("wrap1", 3'd1, FETCH);
    step_and_check("wrap2", 3'd2, NONE);
    step_and_check("wrap3", 3'd3, NONE);
    step_and_check("wrap4", 3'd4, NONE);
    step_and_check("wrap0", 3'd0, T0W);
    step_and_check("wrap5", 3'd1, FETCH);
    goto_t0();

    // ADD / SUB
    run_instr("add", 8'h2F, IO | MI, RO | BI, EO | AI | FI);
    run_instr("sub", 8'h3F, IO | MI, RO | BI, EO | AI | SU | FI);

    // JC, with cf flipping inside T2
    bus.cf    = 1'b0;
    bus.irval = 8'h73;
    step_and_check("jc_t1", 3'd1, FETCH);
    step_and_check("jc_nc", 3'd2, NONE);
    bus.cf = 1'b1;
    check_now("jc_c", 3'd2, IO | J);
    bus.cf = 1'b0;
    check_now("jc_flip", 3'd2, NONE);
    bus.cf = 1'b1;
    check_now("jc_c2", 3'd2, IO | J);
    step_and_check("jc_t3", 3'd3, NONE);
    step_and_check("jc_t4", 3'd4, NONE);
    step_and_check("jc_t0", 3'd0, T0W);

    // JZ, with zf flipping inside T2
    bus.zf    = 1'b0;
    bus.irval = 8'h85;
    step_and_check("jz_t1", 3'd1, FETCH);
    step_and_check("jz_nz", 3'd2, NONE);
    bus.zf = 1'b1;
    check_now("jz_z", 3'd2, IO | J);
    step_and_check("jz_t3", 3'd3, NONE);
    step_and_check("jz_t4", 3'd4, NONE);
    step_and_check("jz_t0", 3'd0, T0W);

    // LDI, JMP, OUT and an unused opcode
    for (int i = 0; i < 4; i++) begin
      run_instr($sformatf("op%0h", ops[i]), ops[i], t2w[i], NONE, NONE);
    end

    // Halt holds at T2 until clr_
    bus.irval = 8'hF0;
    step_and_check("hlt_t1", 3'd1, FETCH);
    step_and_check("hlt_t2", 3'd2, HLT);
    for (int i = 0; i < 10; i++) begin
      step_and_check($sformatf("hlt_hold%0d", i), 3'd2, HLT);
    end
    clr_ = 1'b0;
    check_now("hlt_clr", 3'd0, T0W);
    bus.irval = 8'h00;
    clr_ = 1'b1;
    step_and_check("hlt_sync", 3'd0, T0W);
    step_and_check("hlt_rel", 3'd1, FETCH);

    // Manual program mode during LDA T3
    bus.irval = 8'h1A;
    step_and_check("lda_t2", 3'd2, IO | MI);
    step_and_check("lda_t3", 3'd3, RO | AI);
    bus.prog = 1'b0;
    check_now("prog_off", 3'd0, NONE);
    for (int i = 0; i < 4; i++) begin
      step_and_check($sformatf("prog_hold%0d", i), 3'd0, NONE);
    end
    bus.prog = 1'b1;
    check_now("prog_on", 3'd0, T0W);
    step_and_check("prog_t1", 3'd1, FETCH);

    // Asynchronous reset during STA T3
    bus.irval = 8'h4A;
    step_and_check("sta_t2", 3'd2, IO | MI);
    step_and_check("sta_t3", 3'd3, AO | RI);
    clr_ = 1'b0;
    check_now("sta_clr", 3'd0, T0W);
    clr_ = 1'b1;
    step_and_check("sta_sync", 3'd0, T0W);
    step_and_check("sta_rel", 3'd1, FETCH);

    if (exp_q.size() != 0) check_value("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
